reg_skid_buf: RTL

Two-entry valid/ready register slice (skid buffer) that sits directly upstream of the team's enable-gated data registers. It decouples a streaming producer from a consumer whose readiness may change every cycle, and registers every output, including the ready signal sent back upstream. It sustains one transfer per cycle, preserves order and never drops or duplicates a word. Its registered `o_data`/`o_valid` pair drives the `i_data`/`i_en` inputs of a downstream `reg_rst_y_mode_a_en_y` stage directly.

---
 rtl/reg_skid_buf_if.sv | 32 +++
 rtl/reg_skid_buf.sv | 112 +++++++++++
 2 files changed

// File: rtl/reg_skid_buf_if.sv
// Valid/ready stream bundle for reg_skid_buf: producer-side, consumer-side and occupancy signals.
interface reg_skid_buf_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_ready;
    logic [1:0]            o_cnt;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_cnt
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_cnt
    );
endinterface

// File: rtl/reg_skid_buf.sv
// Two-entry registered valid/ready slice: the main register drives o_data, and the skid register
// absorbs one overflow word so that o_ready can be registered without losing throughput.
module reg_skid_buf #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    reg_skid_buf_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  ready_q;
    logic                  valid_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    logic                  accept;
    logic                  deliver;
    logic                  main_we;
    logic                  main_from_skid;
    logic                  skid_we;

    // Handshakes use the registered flags, so o_ready never depends on i_ready combinationally.
    assign accept  = bus.i_valid && ready_q;
    assign deliver = valid_q && bus.i_ready;

    always_comb begin
        state_d        = state_q;
        main_we        = 1'b0;
        main_from_skid = 1'b0;
        skid_we        = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_we = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && deliver) begin
                    main_we = 1'b1;
                end else if (accept) begin
                    skid_we = 1'b1;
                    state_d = ST_FULL;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    main_we        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        cnt_d = 2'd0;
        case (state_d)
            ST_BUSY: cnt_d = 2'd1;
            ST_FULL: cnt_d = 2'd2;
            default: cnt_d = 2'd0;
        endcase
    end

    // Flags are computed from the next state so every output comes straight off a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            valid_q <= (state_d != ST_EMPTY);
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_we) begin
                main_q <= main_from_skid ? skid_q : bus.i_data;
            end
            if (skid_we) begin
                skid_q <= bus.i_data;
            end
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = main_q;
    assign bus.o_cnt   = cnt_q;
endmodule
